// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with prefetch FIFO and redirect
// Optional build macro: FETCH_TRACE_EN (prints each FIFO push and each redirect)
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] raddr,
   input  logic [7:0] rdata,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic [7:0] out_pc,
   input  logic       out_ready
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = AW + 1;
   localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

   logic [7:0]    fetch_pc_q, fetch_pc_d;
   logic          s0_valid_q, s0_valid_d;
   logic [7:0]    s0_pc_q, s0_pc_d;
   logic          s1_valid_q, s1_valid_d;
   logic [7:0]    s1_pc_q, s1_pc_d;
   logic [7:0]    data_mem_q [DEPTH];
   logic [7:0]    data_mem_d [DEPTH];
   logic [7:0]    pc_mem_q [DEPTH];
   logic [7:0]    pc_mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [1:0]    inflight;
   logic [CW:0]   occupancy;
   logic          issue;
   logic          push;
   logic          pop;

   assign raddr     = fetch_pc_q;
   assign out_valid = (count_q != '0);
   assign out_data  = data_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];

   // Credit check, pipeline advance, FIFO push/pop; redirect overrides everything
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      s0_valid_d = s0_valid_q;
      s0_pc_d    = s0_pc_q;
      s1_valid_d = s1_valid_q;
      s1_pc_d    = s1_pc_q;
      data_mem_d = data_mem_q;
      pc_mem_d   = pc_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      // Bytes already buffered plus bytes still in the memory pipeline must fit
      inflight  = {1'b0, s0_valid_q} + {1'b0, s1_valid_q};
      occupancy = {1'b0, count_q} + {{(CW-1){1'b0}}, inflight};
      issue     = (occupancy < DEPTH_W);
      push      = s1_valid_q;
      pop       = out_valid && out_ready;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         s0_valid_d = 1'b0;
         s1_valid_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         s1_valid_d = s0_valid_q;
         s1_pc_d    = s0_pc_q;
         if (issue) begin
            s0_valid_d = 1'b1;
            s0_pc_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 8'd1;
         end else begin
            s0_valid_d = 1'b0;
         end
         if (push) begin
            data_mem_d[wr_ptr_q] = rdata;
            pc_mem_d[wr_ptr_q]   = s1_pc_q;
            wr_ptr_d             = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage is cleared too so the head reads zero out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         s0_valid_q <= 1'b0;
         s0_pc_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_pc_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         s0_valid_q <= s0_valid_d;
         s0_pc_q    <= s0_pc_d;
         s1_valid_q <= s1_valid_d;
         s1_pc_q    <= s1_pc_d;
         data_mem_q <= data_mem_d;
         pc_mem_q   <= pc_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

`ifdef FETCH_TRACE_EN
   // Simulation trace of captured bytes and redirects
   always @(posedge clk) begin
      if (!rst) begin
         if (redirect)
            $display("#redirect %h", redirect_pc);
         else if (s1_valid_q)
            $display("#fetch[%h] -> %h", s1_pc_q, rdata);
      end
   end
`else
   // Trace disabled: no simulation output
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the 8-bit instruction memory. It drives the memory's read address every cycle and matches returned bytes against its outstanding requests, using the memory's fixed two-edge read latency. Fetched bytes go into a small prefetch FIFO and are presented to the decoder with their PC over a valid/ready handshake. A redirect input flushes the FIFO and restarts fetch at a new PC for branches and jumps.

## Interface
- RESET_PC, 8'h00, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of 2, at least 4.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- raddr  out  8  read address to the instruction memory; registered; presented every cycle.
- rdata  in  8  read data from the instruction memory; belongs to the raddr that was sampled two posedges earlier.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  8  new fetch PC; sampled only when redirect=1.
- out_valid  out  1  FIFO head holds a valid byte.
- out_data  out  8  byte at the FIFO head.
- out_pc  out  8  address of out_data.
- out_ready  in  1  decoder accepts the head this cycle.

## Operation
- Internal state:
  - fetch_pc (drives raddr).
  - 2-stage in-flight pipeline: valid bit + pc per stage.
  - FIFO of DEPTH {pc, data} entries with rd/wr pointers.
  - count, width log2(DEPTH)+1.
- Issue:
  - Condition: count + inflight < DEPTH, where inflight is the number of set in-flight valid bits (0..2).
  - On an issue edge: stage0 <= {1, fetch_pc}, fetch_pc <= fetch_pc + 1. The increment is mod 256, so FF wraps to 00.
  - On a non-issue edge: fetch_pc holds, and stage0.valid <= 0.
  - raddr still equals fetch_pc. The memory reads it, but the data is discarded.
- Pipeline: stage1 <= stage0 every edge.
- Capture: if stage1.valid, then {stage1.pc, rdata} is pushed into the FIFO at the edge.
  - The credit rule guarantees the FIFO is never full when a capture occurs.
- Pop: out_valid && out_ready at an edge removes the FIFO head. Push and pop may occur on the same edge; count is unchanged in that case.
- out_valid = (count != 0). out_data and out_pc come from the FIFO head, registered storage.
- Redirect, at an edge with redirect=1:
  - Priority over issue, capture and pop.
  - count <= 0; both in-flight valid bits cleared; fetch_pc <= redirect_pc.
  - A pop handshake in the same cycle is discarded; the decoder must not treat it as consumed.
- Reset values:
  - raddr = RESET_PC; out_valid = 0; out_data = 0; out_pc = 0.
  - FIFO pointers, count and in-flight valids = 0.
  - All take effect immediately on rst assertion, without waiting for clk.

## Timing
- Cycle n is the interval after posedge n. rst is released before posedge 1.
- Cycle 0: raddr = RESET_PC. The issue is counted at posedge 1.
- Posedge 2: memory data register updates; rdata is valid in cycle 2.
- Posedge 3: byte captured; out_valid = 1 in cycle 3.
- Issue-to-out_valid latency is 3 cycles. The same holds after a redirect: redirect sampled at posedge r gives out_valid at posedge r+3 at the earliest.
- Sustained throughput is 1 byte per cycle with out_ready held at 1. This requires DEPTH ≥ 4.
- With out_ready = 0, at most DEPTH bytes are fetched before issue stops. raddr then holds at the next unfetched PC.
- Issue resumes on the edge after the first pop.

## Configuration
- FETCH_TRACE_EN defined: for every FIFO push, simulation prints "#fetch[<pc>] -> <data>" in hex, plus "#redirect <pc>" on every redirect.
- FETCH_TRACE_EN undefined: no $display statements. Datapath behaviour is identical in both builds.

## Test plan
- Stream: mem[i] = i ^ 8'hA5, out_ready = 1 after reset.
  - out_valid rises in cycle 3.
  - Accepted pairs are (00,A5), (01,A4), (02,A7), … at one per cycle with no gaps.
- Backpressure: out_ready = 0 for 10 cycles from reset.
  - Exactly 4 bytes are buffered and raddr holds at 04.
  - After out_ready = 1, PCs 00..07 are accepted in order with no loss or duplicates.
- Redirect: redirect = 1 with redirect_pc = 8'h80 while streaming.
  - No stale byte is accepted.
  - out_valid is low for 3 cycles, then the first accepted pc is 80.
- Wrap: redirect to 8'hFE.
  - Accepted PCs are FE, FF, 00, 01 with the matching mem data.
- Redirect colliding with pop: redirect = 1 and out_ready = 1 with out_valid = 1 in the same cycle.
  - FIFO is empty next cycle.
  - Next accepted entry is redirect_pc.
- Async reset mid-stream: rst pulsed between edges with out_valid = 1.
  - out_valid drops before the next posedge.
  - After release, the fetch restarts at 00 with 3-cycle latency.
